// File: rtl/cmd_packet_tx.sv
// Command packet encoder: turns one data-update or freq-update request into the byte
// stream decoded by diff_freq_serial_out, driving a UART through tx_start/tx_done.
module cmd_packet_tx #(
  parameter int          DATA_BIT       = 32,
  parameter int          PACK_NUM       = DATA_BIT / 8,
  parameter logic [7:0]  CMD_DATA       = 8'h01,
  parameter logic [7:0]  CMD_FREQ       = 8'h02,
  parameter int          GAP_CYCLES     = 0,
  parameter int          TIMEOUT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_type_i,
  input  logic [3:0]          channel_i,
  input  logic                mode_i,
  input  logic [DATA_BIT-1:0] pattern_i,
  input  logic [7:0]          slow_period_i,
  input  logic [7:0]          fast_period_i,
  output logic                tx_start_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_done_tick_i,
  output logic                busy_o,
  output logic                done_tick_o,
  output logic                error_tick_o,
  output logic [2:0]          dbg_state_o
);

  // Handshake: a request transfers on a clk_i edge where req_valid_i && req_ready_o;
  // ready is high only in IDLE, and every request field is captured on that edge.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int CW       = $clog2(PACK_NUM + 3);
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CW-1:0] LAST_DATA = CW'(PACK_NUM + 1);
  localparam logic [CW-1:0] LAST_FREQ = CW'(PACK_NUM + 2);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [TW-1:0]         wait_q, wait_d;
  logic                  typ_q, typ_d;
  logic [3:0]            ch_q, ch_d;
  logic                  mode_q, mode_d;
  logic [DATA_BIT-1:0]   pat_q, pat_d;
  logic [7:0]            slow_q, slow_d;
  logic [7:0]            fast_q, fast_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [CW-1:0]         last_idx;
  logic                  timed_out;

  // Byte order: command, pattern LSB first, then control byte or slow/fast periods.
  function automatic logic [7:0] pick_byte(
    input logic [CW-1:0]       idx,
    input logic                typ,
    input logic [3:0]          ch,
    input logic                mode,
    input logic [DATA_BIT-1:0] pat,
    input logic [7:0]          slow,
    input logic [7:0]          fast
  );
    logic [7:0] b;
    b = 8'h00;
    if (idx == '0) begin
      b = typ ? CMD_FREQ : CMD_DATA;
    end else if (int'(idx) <= PACK_NUM) begin
      b = 8'(pat >> (8 * (int'(idx) - 1)));
    end else if (int'(idx) == PACK_NUM + 1) begin
      b = typ ? slow : {ch, 1'b0, mode, 2'b01};
    end else begin
      b = fast;
    end
    return b;
  endfunction

  assign last_idx  = typ_q ? LAST_FREQ : LAST_DATA;
  assign timed_out = (TIMEOUT_CYCLES > 0) && (wait_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      wait_q    <= '0;
      typ_q     <= 1'b0;
      ch_q      <= '0;
      mode_q    <= 1'b0;
      pat_q     <= '0;
      slow_q    <= '0;
      fast_q    <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      wait_q    <= wait_d;
      typ_q     <= typ_d;
      ch_q      <= ch_d;
      mode_q    <= mode_d;
      pat_q     <= pat_d;
      slow_q    <= slow_d;
      fast_q    <= fast_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    wait_d    = wait_q;
    typ_d     = typ_q;
    ch_d      = ch_q;
    mode_d    = mode_q;
    pat_d     = pat_q;
    slow_d    = slow_q;
    fast_d    = fast_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_START;
          cnt_d   = '0;
          typ_d   = req_type_i;
          ch_d    = channel_i;
          mode_d  = mode_i;
          pat_d   = pattern_i;
          slow_d  = slow_period_i;
          fast_d  = fast_period_i;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        // A done tick in the same cycle as the timeout still completes the byte.
        if (tx_done_tick_i) begin
          if (cnt_q == last_idx) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            gap_d   = '0;
            state_d = (GAP_CYCLES > 0) ? S_GAP : S_START;
          end
        end else if (timed_out) begin
          state_d = S_IDLE;
        end else if (TIMEOUT_CYCLES > 0) begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          state_d = S_START;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The byte register loads only on the way into START, so it holds through WAIT and IDLE.
  always_comb begin
    tx_data_d = tx_data_q;
    if (state_d == S_START) begin
      tx_data_d = pick_byte(cnt_d, typ_d, ch_d, mode_d, pat_d, slow_d, fast_d);
    end
  end

  always_comb begin
    tx_start_o   = (state_q == S_START);
    busy_o       = (state_q != S_IDLE);
    req_ready_o  = (state_q == S_IDLE);
    done_tick_o  = (state_q == S_DONE);
    error_tick_o = (state_q == S_WAIT) && !tx_done_tick_i && timed_out;
    tx_data_o    = tx_data_q;
    dbg_state_o  = state_q;
  end

endmodule
